gt_load_sequencer: RTL and testbench
====================================

Name: gt_load_sequencer

Overview:
- Register-side controller that sequences the multi-lane GT transmit datapath: resets the lanes, loads each enabled lane's waveform SRAM from a word stream, arms, then issues a single synchronous start.
- Sits between the AXI-lite register block / register FIFO and the GT datapath, in the register clock domain.
- Replaces software bit-banging of per-lane RAM writes and start/reset strobes with one command.

Parameters:
- NUM_LANES, 6, number of GT lanes (mask width); 1..8.
- ADDR_W, 8, SRAM word address width; also the cap width.
- RST_CYCLES, 16, cycles gt_reset is held high at sequence start; >=1.
- ARM_CYCLES, 4, idle cycles between the last RAM write and gt_start; >=1.

Ports:
- ps_clk  in  1  register clock; only clock of the block.
- ps_rstb  in  1  asynchronous active-low reset.
- cmd_go  in  1  one-cycle command strobe.
- cmd_abort  in  1  one-cycle abort strobe.
- cmd_lane_mask  in  NUM_LANES  lanes to load; bit i = lane i.
- cmd_cap  in  ADDR_W  words per lane, 1..2^ADDR_W-1.
- s_tdata  in  32  waveform word stream.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- ram_lane  out  3  target lane of the current write.
- ram_addr  out  ADDR_W  SRAM address of the current write.
- ram_data  out  32  SRAM write data.
- ram_we  out  1  SRAM write enable, one cycle per word.
- gt_reset  out  1  datapath reset, level.
- gt_start  out  1  datapath start, one-cycle pulse.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (bad command or abort).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and latched command cleared.
- FSM states: IDLE, RESET, LOAD, ARM, START, FIN.
- IDLE: cmd_go sampled at edge T, with mask!=0 and cap!=0 -> latch mask and cap; RESET from T+1; busy=1 from T+1.
- IDLE: cmd_go with mask==0 or cap==0 -> err=1 in cycle T+1; stay IDLE; no other output changes.
- cmd_go while busy: ignored, no err.
- RESET: gt_reset=1 for exactly RST_CYCLES cycles, then LOAD. gt_reset is 0 in every other state.
- LOAD:
  - s_tready=1 only in LOAD.
  - Word order is lane-major: lowest enabled lane first, addr 0..cap-1; then the next enabled lane. Disabled lanes are skipped with no dead cycle.
  - Handshake = s_tvalid&&s_tready at an edge. The next cycle drives ram_we=1 with that word's lane, addr and data (1-cycle registered latency).
  - ram_we=0 on cycles with no handshake. ram_lane/addr/data hold their last values when idle.
  - Stalls (s_tvalid=0) are unbounded; no timeout.
  - After the handshake of word popcount(mask)*cap, s_tready drops the next cycle and the FSM enters ARM.
- ARM: ARM_CYCLES cycles, which include the final ram_we cycle, then START.
- START: gt_start=1 for one cycle, then FIN.
- FIN: done=1 for one cycle; busy=0 from the following cycle; return to IDLE.
- cmd_abort in any non-IDLE state:
  - Next cycle: IDLE, busy=0, s_tready=0, gt_reset=0, err=1 for one cycle.
  - gt_start and done are not produced.
  - A handshake accepted at the abort edge is discarded: no ram_we for it.
- cmd_abort in IDLE: no effect.
- cmd_go and cmd_abort in the same cycle: abort wins if busy; go is processed if IDLE.
- Counters: addr counter wraps to 0 at cap-1 and advances the lane pointer; lane pointer search over the latched mask is combinational, one lane per wrap.
- Total words per sequence is at most NUM_LANES*(2^ADDR_W-1); word counter is 11 bits at defaults.
- Asynchronous reset mid-sequence: immediate return to reset state; the partially loaded RAM contents are not cleaned up.

Test Plan:
- Basic: mask=6'b000101, cap=3, s_tvalid held 1, words 0xA0..0xA5.
  - gt_reset high 16 cycles.
  - ram_we writes (lane,addr,data) = (0,0,A0)(0,1,A1)(0,2,A2)(2,0,A3)(2,1,A4)(2,2,A5) on consecutive cycles.
  - gt_start 4 cycles after the first cycle of the final write; done the next cycle; busy then 0.
- Backpressure: mask=6'b100000, cap=4, s_tvalid toggling 1,0,1,0.
  - Exactly 4 ram_we pulses to lane 5, addr 0..3, each one cycle after its handshake.
  - No write on stall cycles.
- Bad command: cmd_go with mask=0, then with cap=0 -> err pulses in both cases; busy, gt_reset and ram_we stay 0.
- Abort: mask=6'b111111, cap=8, abort after 10 words.
  - err pulse; busy 0 next cycle; no gt_start, no done.
  - A new go then restarts cleanly at lane 0 addr 0.
- Full sweep: mask=6'b111111, cap=255 -> 1530 writes, addr wraps 254->0 at each lane change, single gt_start.
- Go while busy plus async reset mid-LOAD:
  - Second go is ignored (no err).
  - Asserting ps_rstb low clears all outputs immediately.

Source files
------------

// File: rtl/gt_load_sequencer.sv
// Register-domain sequencer for the GT transmit datapath: reset lanes, stream
// waveform words into each enabled lane's SRAM, arm, then fire one start pulse.
module gt_load_sequencer #(
    parameter int NUM_LANES  = 6,
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 16,
    parameter int ARM_CYCLES = 4
) (
    input  logic                 ps_clk,
    input  logic                 ps_rstb,
    input  logic                 cmd_go,
    input  logic                 cmd_abort,
    input  logic [NUM_LANES-1:0] cmd_lane_mask,
    input  logic [ADDR_W-1:0]    cmd_cap,
    input  logic [31:0]          s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [2:0]           ram_lane,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [31:0]          ram_data,
    output logic                 ram_we,
    output logic                 gt_reset,
    output logic                 gt_start,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARM   = 3'd3,
        ST_START = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t                state_r;
    logic [NUM_LANES-1:0]  mask_r;
    logic [ADDR_W-1:0]     cap_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [2:0]            lane_r;
    logic [15:0]           phase_cnt_r;

    logic [3:0]            first_lane_s;
    logic [3:0]            next_lane_s;
    logic                  cmd_ok_s;
    logic                  addr_wrap_s;
    logic                  last_word_s;
    logic                  hs_s;

    // Lowest enabled lane at index >= from; bit 3 set means no such lane.
    function automatic logic [3:0] find_lane(input logic [NUM_LANES-1:0] mask,
                                             input logic [3:0] from);
        logic [3:0] res;
        res = 4'b1000;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                res = 4'(i);
            end
        end
        return res;
    endfunction

    // Lane search, word-boundary detection and stream handshake.
    always_comb begin
        first_lane_s = find_lane(cmd_lane_mask, 4'd0);
        next_lane_s  = find_lane(mask_r, {1'b0, lane_r} + 4'd1);
        cmd_ok_s     = !first_lane_s[3] && (cmd_cap != {ADDR_W{1'b0}});
        addr_wrap_s  = (addr_r == (cap_r - ADDR_W'(1)));
        last_word_s  = addr_wrap_s && next_lane_s[3];
        hs_s         = s_tvalid && s_tready;
    end

    // Sequencer FSM with all outputs registered; abort overrides every busy state.
    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            state_r     <= ST_IDLE;
            mask_r      <= {NUM_LANES{1'b0}};
            cap_r       <= {ADDR_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            lane_r      <= 3'd0;
            phase_cnt_r <= 16'd0;
            s_tready    <= 1'b0;
            ram_lane    <= 3'd0;
            ram_addr    <= {ADDR_W{1'b0}};
            ram_data    <= 32'd0;
            ram_we      <= 1'b0;
            gt_reset    <= 1'b0;
            gt_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            gt_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (cmd_abort && (state_r != ST_IDLE)) begin
                // A word accepted on this edge is dropped: ram_we stays low.
                state_r  <= ST_IDLE;
                busy     <= 1'b0;
                s_tready <= 1'b0;
                gt_reset <= 1'b0;
                err      <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cmd_go) begin
                            if (cmd_ok_s) begin
                                mask_r      <= cmd_lane_mask;
                                cap_r       <= cmd_cap;
                                lane_r      <= first_lane_s[2:0];
                                addr_r      <= {ADDR_W{1'b0}};
                                phase_cnt_r <= 16'd0;
                                state_r     <= ST_RESET;
                                busy        <= 1'b1;
                                gt_reset    <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_RESET: begin
                        if (phase_cnt_r == 16'(RST_CYCLES - 1)) begin
                            state_r  <= ST_LOAD;
                            gt_reset <= 1'b0;
                            s_tready <= 1'b1;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + 16'd1;
                        end
                    end
                    ST_LOAD: begin
                        if (hs_s) begin
                            ram_we   <= 1'b1;
                            ram_lane <= lane_r;
                            ram_addr <= addr_r;
                            ram_data <= s_tdata;
                            if (last_word_s) begin
                                s_tready    <= 1'b0;
                                phase_cnt_r <= 16'd0;
                                state_r     <= ST_ARM;
                            end else if (addr_wrap_s) begin
                                addr_r <= {ADDR_W{1'b0}};
                                lane_r <= next_lane_s[2:0];
                            end else begin
                                addr_r <= addr_r + ADDR_W'(1);
                            end
                        end
                    end
                    ST_ARM: begin
                        // The arm window starts with the final ram_we cycle.
                        if (phase_cnt_r == 16'(ARM_CYCLES - 1)) begin
                            state_r  <= ST_START;
                            gt_start <= 1'b1;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + 16'd1;
                        end
                    end
                    ST_START: begin
                        state_r <= ST_FIN;
                        done    <= 1'b1;
                    end
                    ST_FIN: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        s_tready <= 1'b0;
                        gt_reset <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gt_load_sequencer.sv
// Self-checking bench for gt_load_sequencer: randomized stream stimulus compared
// against a lane-major write list and cycle-timing rules built in the bench.
module tb_gt_load_sequencer;

    localparam int NL   = 6;
    localparam int AW   = 8;
    localparam int RSTC = 16;
    localparam int ARMC = 4;

    logic          ps_clk = 1'b0;
    logic          ps_rstb = 1'b0;
    logic          cmd_go = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [NL-1:0] cmd_lane_mask = '0;
    logic [AW-1:0] cmd_cap = '0;
    logic [31:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [2:0]    ram_lane;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          ram_we, gt_reset, gt_start, busy, done, err;

    gt_load_sequencer #(.NUM_LANES(NL), .ADDR_W(AW), .RST_CYCLES(RSTC), .ARM_CYCLES(ARMC)) dut (
        .ps_clk(ps_clk), .ps_rstb(ps_rstb), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
        .cmd_lane_mask(cmd_lane_mask), .cmd_cap(cmd_cap), .s_tdata(s_tdata),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .ram_lane(ram_lane),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .gt_reset(gt_reset), .gt_start(gt_start), .busy(busy), .done(done), .err(err)
    );

    always #5 ps_clk = ~ps_clk;

    typedef struct {
        logic [2:0]  lane;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gtr_cnt, gtr_first, busy_last, go_cyc;
    wr_t         wr_q[$];
    int          start_q[$], done_q[$], err_q[$], hs_cyc_q[$];
    logic [31:0] hs_data_q[$];
    logic [2:0]  exp_lane_q[$];
    logic [7:0]  exp_addr_q[$];

    always @(posedge ps_clk) cyc <= cyc + 1;

    // Output log: every write, pulse and gt_reset/busy level, stamped with the cycle.
    always @(negedge ps_clk) begin
        if (ram_we === 1'b1) wr_q.push_back('{lane: ram_lane, addr: ram_addr, data: ram_data, cyc: cyc});
        if (gt_start === 1'b1) start_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
        if (err === 1'b1) err_q.push_back(cyc);
        if (gt_reset === 1'b1) begin
            if (gtr_cnt == 0) gtr_first = cyc;
            gtr_cnt++;
        end
        if (busy === 1'b1) busy_last = cyc;
    end

    // Reference: lane-major list of (lane, addr) for a mask and cap.
    function automatic void build_exp(input logic [NL-1:0] m, input int cap);
        exp_lane_q.delete();
        exp_addr_q.delete();
        for (int l = 0; l < NL; l++)
            if (m[l])
                for (int a = 0; a < cap; a++) begin
                    exp_lane_q.push_back(3'(l));
                    exp_addr_q.push_back(8'(a));
                end
    endfunction

    task automatic launch(input logic [NL-1:0] m, input logic [AW-1:0] c);
        @(posedge ps_clk);
        #1;
        wr_q.delete(); start_q.delete(); done_q.delete(); err_q.delete();
        hs_cyc_q.delete(); hs_data_q.delete();
        gtr_cnt = 0; gtr_first = -1; busy_last = -1;
        @(negedge ps_clk);
        cmd_go = 1'b1; cmd_lane_mask = m; cmd_cap = c; go_cyc = cyc;
        @(negedge ps_clk);
        cmd_go = 1'b0;
    endtask

    // mode 0: random valid (70%), 1: toggle 1,0,1,0..., 2: valid held high.
    task automatic stream(input int n, input int mode, input logic [31:0] base, output int got);
        int guard;
        got = 0;
        guard = 0;
        while (got < n && guard < 20000) begin
            @(negedge ps_clk);
            case (mode)
                0:       s_tvalid = ($urandom_range(0, 99) < 70);
                1:       s_tvalid = !s_tvalid;
                default: s_tvalid = 1'b1;
            endcase
            s_tdata = base + 32'(got);
            if (s_tvalid && s_tready === 1'b1) begin
                hs_cyc_q.push_back(cyc);
                hs_data_q.push_back(s_tdata);
                got++;
            end
            guard++;
        end
        @(negedge ps_clk);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!(done_q.size() > 0 && busy === 1'b0) && k < 400) begin
            @(negedge ps_clk);
            k++;
        end
        repeat (3) @(negedge ps_clk);
        checks++;
        if (k >= 400) begin
            failures++;
            $display("FAIL %s_timeout: done pulses %0d busy %b, required a done then busy low", name, done_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ps_clk);
        checks++;
        if ({s_tready, ram_we, gt_reset, gt_start, busy, done, err, ram_lane, ram_addr, ram_data} !== '0) begin
            failures++;
            $display("FAIL reset_hold: outputs nonzero during reset (busy=%b tready=%b gt_reset=%b), required all 0", busy, s_tready, gt_reset);
        end
        ps_rstb = 1'b1;
        repeat (3) @(negedge ps_clk);
        checks++;
        if ({s_tready, ram_we, gt_reset, gt_start, busy, done, err} !== 7'd0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b tready=%b err=%b after release, required all 0", busy, s_tready, err);
        end
    endtask

    task automatic test_basic();
        int got, bad;
        launch(6'b000101, 8'd3);
        stream(6, 2, 32'hA0, got);
        wait_done("basic");
        build_exp(6'b000101, 3);
        checks++;
        if (gtr_cnt != RSTC || gtr_first != go_cyc + 1) begin
            failures++;
            $display("FAIL basic_gt_reset: %0d cycles from %0d, required %0d from %0d", gtr_cnt, gtr_first, RSTC, go_cyc + 1);
        end
        checks++;
        if (hs_cyc_q.size() == 0 || hs_cyc_q[0] != go_cyc + 1 + RSTC) begin
            failures++;
            $display("FAIL basic_first_hs: got %0d handshakes, first at %0d, required first at %0d", got, hs_cyc_q.size() > 0 ? hs_cyc_q[0] : -1, go_cyc + 1 + RSTC);
        end
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < exp_lane_q.size(); i++)
            if (wr_q[i].lane !== exp_lane_q[i] || wr_q[i].addr !== exp_addr_q[i] ||
                wr_q[i].data !== 32'hA0 + 32'(i) || wr_q[i].cyc != wr_q[0].cyc + i) bad++;
        checks++;
        if (wr_q.size() != 6 || bad != 0 || wr_q[0].cyc != go_cyc + 2 + RSTC) begin
            failures++;
            $display("FAIL basic_writes: %0d writes, %0d wrong, first at %0d; required 6 consecutive from %0d", wr_q.size(), bad, wr_q.size() > 0 ? wr_q[0].cyc : -1, go_cyc + 2 + RSTC);
        end
        checks++;
        if (start_q.size() != 1 || wr_q.size() == 0 || start_q[0] != wr_q[wr_q.size() - 1].cyc + ARMC) begin
            failures++;
            $display("FAIL basic_start: %0d start pulses, first at %0d, required 1 at last write + %0d", start_q.size(), start_q.size() > 0 ? start_q[0] : -1, ARMC);
        end
        checks++;
        if (done_q.size() != 1 || start_q.size() == 0 || done_q[0] != start_q[0] + 1 || busy_last != done_q[0]) begin
            failures++;
            $display("FAIL basic_done: %0d done pulses at %0d, busy last %0d, required 1 done right after start with busy ending there", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, busy_last);
        end
        checks++;
        if (err_q.size() != 0) begin
            failures++;
            $display("FAIL basic_err: %0d err pulses, required 0", err_q.size());
        end
    endtask

    task automatic test_backpressure();
        int got, bad;
        logic [31:0] base;
        base = $urandom;
        launch(6'b100000, 8'd4);
        stream(4, 1, base, got);
        wait_done("backpressure");
        build_exp(6'b100000, 4);
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < hs_data_q.size(); i++) begin
            if (wr_q[i].lane !== exp_lane_q[i] || wr_q[i].addr !== exp_addr_q[i] ||
                wr_q[i].data !== hs_data_q[i] || wr_q[i].cyc != hs_cyc_q[i] + 1) bad++;
            if (i > 0 && hs_cyc_q[i] != hs_cyc_q[i - 1] + 2) bad++;
        end
        checks++;
        if (got != 4 || wr_q.size() != 4 || bad != 0) begin
            failures++;
            $display("FAIL bp_writes: %0d handshakes, %0d writes, %0d wrong; required 4 lane-5 writes one cycle after each handshake", got, wr_q.size(), bad);
        end
        checks++;
        if (start_q.size() != 1 || done_q.size() != 1) begin
            failures++;
            $display("FAIL bp_pulses: start %0d done %0d, required 1 and 1", start_q.size(), done_q.size());
        end
    endtask

    task automatic test_bad_cmd();
        for (int k = 0; k < 2; k++) begin
            launch(k == 0 ? 6'b000000 : 6'b000011, k == 0 ? 8'd5 : 8'd0);
            repeat (6) @(negedge ps_clk);
            checks++;
            if (err_q.size() != 1 || err_q[0] != go_cyc + 1) begin
                failures++;
                $display("FAIL bad_cmd_err%0d: %0d err pulses, first at %0d, required 1 at %0d", k, err_q.size(), err_q.size() > 0 ? err_q[0] : -1, go_cyc + 1);
            end
            checks++;
            if (busy_last != -1 || gtr_cnt != 0 || wr_q.size() != 0) begin
                failures++;
                $display("FAIL bad_cmd_quiet%0d: busy last %0d, gt_reset cycles %0d, writes %0d, required none", k, busy_last, gtr_cnt, wr_q.size());
            end
        end
    endtask

    task automatic test_abort();
        int got, ab, bad;
        logic abort_hs;
        launch(6'b111111, 8'd8);
        stream(10, 0, $urandom, got);
        @(negedge ps_clk);
        cmd_abort = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; ab = cyc;
        abort_hs = (s_tready === 1'b1);
        @(negedge ps_clk);
        cmd_abort = 1'b0; s_tvalid = 1'b0;
        checks++;
        if (!abort_hs || busy !== 1'b0 || s_tready !== 1'b0 || err !== 1'b1 || gt_reset !== 1'b0) begin
            failures++;
            $display("FAIL abort_next: hs_at_abort=%b busy=%b tready=%b err=%b gt_reset=%b, required 1,0,0,1,0", abort_hs, busy, s_tready, err, gt_reset);
        end
        repeat (40) @(negedge ps_clk);
        checks++;
        if (got != 10 || wr_q.size() != 10 || err_q.size() != 1 || err_q[0] != ab + 1 ||
            start_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL abort_after: writes %0d err %0d start %0d done %0d, required 10 writes, 1 err, no start/done", wr_q.size(), err_q.size(), start_q.size(), done_q.size());
        end
        launch(6'b111111, 8'd2);
        stream(12, 0, $urandom, got);
        wait_done("abort_restart");
        build_exp(6'b111111, 2);
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < hs_data_q.size(); i++)
            if (wr_q[i].lane !== exp_lane_q[i] || wr_q[i].addr !== exp_addr_q[i] ||
                wr_q[i].data !== hs_data_q[i] || wr_q[i].cyc != hs_cyc_q[i] + 1) bad++;
        checks++;
        if (wr_q.size() != 12 || bad != 0 || wr_q[0].lane !== 3'd0 || wr_q[0].addr !== 8'd0 || start_q.size() != 1) begin
            failures++;
            $display("FAIL abort_restart: %0d writes, %0d wrong, %0d starts, required 12 from lane 0 addr 0 and 1 start", wr_q.size(), bad, start_q.size());
        end
    endtask

    task automatic test_full_sweep();
        int got, bad, first_bad;
        launch(6'b111111, 8'd255);
        stream(1530, 0, $urandom, got);
        wait_done("full");
        build_exp(6'b111111, 255);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < wr_q.size() && i < hs_data_q.size() && i < exp_lane_q.size(); i++)
            if (wr_q[i].lane !== exp_lane_q[i] || wr_q[i].addr !== exp_addr_q[i] ||
                wr_q[i].data !== hs_data_q[i] || wr_q[i].cyc != hs_cyc_q[i] + 1) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        checks++;
        if (got != 1530 || wr_q.size() != 1530 || bad != 0) begin
            failures++;
            $display("FAIL full_writes: %0d handshakes, %0d writes, %0d wrong (first %0d), required 1530 lane-major writes", got, wr_q.size(), bad, first_bad);
        end
        checks++;
        if (start_q.size() != 1 || wr_q.size() == 0 || start_q[0] != wr_q[wr_q.size() - 1].cyc + ARMC) begin
            failures++;
            $display("FAIL full_start: %0d starts, required 1 at last write + %0d", start_q.size(), ARMC);
        end
    endtask

    task automatic test_random();
        int got, bad, n;
        logic [NL-1:0] m;
        logic [AW-1:0] c;
        for (int it = 0; it < 6; it++) begin
            m = NL'($urandom_range(1, 63));
            c = AW'($urandom_range(1, 7));
            n = $countones(m) * int'(c);
            launch(m, c);
            stream(n, 0, $urandom, got);
            wait_done("random");
            build_exp(m, int'(c));
            bad = 0;
            for (int i = 0; i < wr_q.size() && i < hs_data_q.size() && i < exp_lane_q.size(); i++)
                if (wr_q[i].lane !== exp_lane_q[i] || wr_q[i].addr !== exp_addr_q[i] ||
                    wr_q[i].data !== hs_data_q[i] || wr_q[i].cyc != hs_cyc_q[i] + 1) bad++;
            checks++;
            if (wr_q.size() != n || bad != 0) begin
                failures++;
                $display("FAIL random_writes%0d: mask %b cap %0d, %0d writes, %0d wrong, required %0d", it, m, c, wr_q.size(), bad, n);
            end
            checks++;
            if (start_q.size() != 1 || done_q.size() != 1 || wr_q.size() == 0 ||
                start_q[0] != wr_q[wr_q.size() - 1].cyc + ARMC || done_q[0] != start_q[0] + 1) begin
                failures++;
                $display("FAIL random_timing%0d: starts %0d dones %0d, required 1 start at last write + %0d and done right after", it, start_q.size(), done_q.size(), ARMC);
            end
        end
    endtask

    task automatic test_busy_go_and_reset();
        int got;
        launch(6'b000011, 8'd10);
        stream(5, 2, $urandom, got);
        @(negedge ps_clk);
        cmd_go = 1'b1; cmd_lane_mask = 6'b111111; cmd_cap = 8'd3;
        @(negedge ps_clk);
        cmd_go = 1'b0;
        repeat (3) @(negedge ps_clk);
        checks++;
        if (err_q.size() != 0 || busy !== 1'b1 || wr_q.size() != 5) begin
            failures++;
            $display("FAIL busy_go: err pulses %0d busy %b writes %0d, required 0, 1, 5", err_q.size(), busy, wr_q.size());
        end
        #1;
        ps_rstb = 1'b0;
        #1;
        checks++;
        if ({s_tready, ram_we, gt_reset, gt_start, busy, done, err, ram_lane, ram_addr, ram_data} !== '0) begin
            failures++;
            $display("FAIL async_reset: busy=%b tready=%b lane=%0d addr=%0d, required all outputs 0 at once", busy, s_tready, ram_lane, ram_addr);
        end
        @(negedge ps_clk);
        ps_rstb = 1'b1;
        repeat (3) @(negedge ps_clk);
        checks++;
        if (busy !== 1'b0 || s_tready !== 1'b0 || gt_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b tready=%b gt_reset=%b, required idle", busy, s_tready, gt_reset);
        end
    endtask

    initial begin
        gtr_cnt = 0; gtr_first = -1; busy_last = -1; go_cyc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_cmd();
        test_abort();
        test_full_sweep();
        test_random();
        test_busy_go_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
